transfer_channel_rx: RTL and testbench

TRANSFER_CHANNEL_RX -- requirements
Module: transfer_channel_rx

---
 rtl/transfer_channel_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_transfer_channel_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/transfer_channel_rx.sv
//------------------------------------------------------------------------------
// Module      : transfer_channel_rx
// Description : Serial command/payload receiver. Bits are shifted in MSB
//               first; completed words are decoded as commands, or are
//               stored in a small payload FIFO after a data-follows command.
//               Optional macro TRANSFER_PARITY_EN adds a trailing even-parity
//               bit to every frame and discards frames that fail it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module transfer_channel_rx #(
   parameter int WORD_W      = 8,
   parameter int DEPTH       = 4,
   parameter int PAYLOAD_LEN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dataIn,
   input  logic              bitValid,
   input  logic              readyForTransferIn,
   output logic              readyForTransferOut,
   output logic [1:0]        localScannerOut,
   output logic [WORD_W-1:0] dataOut,
   output logic              dataAscii,
   output logic              dataValid,
   input  logic              dataReady,
   output logic              fifoFull,
   output logic              overflow,
   output logic              parityErr
);

`ifdef TRANSFER_PARITY_EN
   localparam int c_FRAME_W = WORD_W + 1;
`else
   localparam int c_FRAME_W = WORD_W;
`endif
   localparam int c_CNT_W = $clog2(c_FRAME_W);
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_PAY_W = 8;

   localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_FRAME_W - 1);
   localparam logic [c_PAY_W-1:0] c_LAST_PAY = c_PAY_W'(PAYLOAD_LEN - 1);
   localparam logic [c_PTR_W:0]   c_FULL     = (c_PTR_W + 1)'(DEPTH);

   localparam logic [WORD_W-1:0] c_CMD_FLUSH = WORD_W'(1);
   localparam logic [WORD_W-1:0] c_CMD_RDY2  = WORD_W'(2);
   localparam logic [WORD_W-1:0] c_CMD_SCAN  = WORD_W'(3);
   localparam logic [WORD_W-1:0] c_CMD_RDY4  = WORD_W'(4);
   localparam logic [WORD_W-1:0] c_CMD_BIN   = WORD_W'(7);
   localparam logic [WORD_W-1:0] c_CMD_ASCII = WORD_W'(8);

   localparam logic [0:0] c_ST_CMD  = 1'b0;
   localparam logic [0:0] c_ST_DATA = 1'b1;

   logic [c_FRAME_W-2:0] r_shift;
   logic [c_CNT_W-1:0]   r_bitCnt;
   logic [c_PAY_W-1:0]   r_payCnt;
   logic [0:0]           r_state;
   logic [0:0]           w_stateNext;
   logic                 r_ascii;
   logic                 r_rdy;
   logic [1:0]           r_scan;

   logic [c_FRAME_W-1:0] w_frame;
   logic [WORD_W-1:0]    w_data;
   logic                 w_complete;
   logic                 w_parityOk;
   logic                 w_wordDone;
   logic                 w_lastPay;
   logic                 w_isDataCmd;

   logic                 w_rdyNext;
   logic [1:0]           w_scanNext;
   logic                 w_push;

   logic [WORD_W:0]      r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wrPtr;
   logic [c_PTR_W-1:0]   r_rdPtr;
   logic [c_PTR_W:0]     r_count;
   logic                 r_overflow;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_pushOk;

   // The frame as it stands including the bit arriving on this edge.
   assign w_frame    = {r_shift, dataIn};
   assign w_complete = bitValid && (r_bitCnt == c_LAST_BIT);

`ifdef TRANSFER_PARITY_EN
   assign w_data     = w_frame[c_FRAME_W-1:1];
   assign w_parityOk = ~(^w_frame);
`else
   assign w_data     = w_frame;
   assign w_parityOk = 1'b1;
`endif

   assign w_wordDone  = w_complete && w_parityOk;
   assign w_lastPay   = (r_payCnt == c_LAST_PAY);
   assign w_isDataCmd = (w_data == c_CMD_BIN) || (w_data == c_CMD_ASCII);

   // Shift register and bit counter; counter wraps after the last frame bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift  <= '0;
         r_bitCnt <= '0;
      end else if (bitValid) begin
         r_shift  <= w_frame[c_FRAME_W-2:0];
         r_bitCnt <= w_complete ? '0 : r_bitCnt + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= c_ST_CMD;
      else     r_state <= w_stateNext;
   end

   // FSM next state: enter DATA on a data-follows command, leave after the last payload word.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         c_ST_CMD:  if (w_wordDone && w_isDataCmd) w_stateNext = c_ST_DATA;
         c_ST_DATA: if (w_wordDone && w_lastPay)   w_stateNext = c_ST_CMD;
         default:   w_stateNext = c_ST_CMD;
      endcase
   end

   // FSM outputs: command decode in CMD, payload push in DATA.
   always_comb begin
      w_rdyNext  = r_rdy;
      w_scanNext = 2'b00;
      w_push     = 1'b0;
      case (r_state)
         c_ST_CMD: begin
            if (w_wordDone) begin
               case (w_data)
                  c_CMD_FLUSH: begin
                     w_rdyNext  = 1'b0;
                     w_scanNext = 2'b10;
                  end
                  c_CMD_RDY2, c_CMD_RDY4, c_CMD_BIN, c_CMD_ASCII:
                     w_rdyNext = readyForTransferIn;
                  c_CMD_SCAN: begin
                     w_rdyNext  = readyForTransferIn;
                     w_scanNext = 2'b01;
                  end
                  default: w_rdyNext = 1'b0;
               endcase
            end
         end
         c_ST_DATA: begin
            if (w_wordDone) begin
               w_push    = 1'b1;
               w_rdyNext = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered handshake outputs, payload counter and payload mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdy    <= 1'b0;
         r_scan   <= 2'b00;
         r_payCnt <= '0;
         r_ascii  <= 1'b0;
      end else begin
         r_rdy  <= w_rdyNext;
         r_scan <= w_scanNext;
         if (w_push) r_payCnt <= w_lastPay ? '0 : r_payCnt + 1'b1;
         if (r_state == c_ST_CMD && w_wordDone && w_isDataCmd)
            r_ascii <= (w_data == c_CMD_ASCII);
      end
   end

`ifdef TRANSFER_PARITY_EN
   logic r_parityErr;

   // Parity failure pulse, one cycle per rejected frame.
   always_ff @(posedge clk) begin
      if (rst) r_parityErr <= 1'b0;
      else     r_parityErr <= w_complete && !w_parityOk;
   end
   assign parityErr = r_parityErr;
`else
   assign parityErr = 1'b0;
`endif

   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign w_full   = (r_count == c_FULL);
   assign w_pop    = (r_count != '0) && dataReady;
   assign w_pushOk = w_push && (!w_full || w_pop);

   // FIFO storage; contents need no reset since dataValid qualifies them.
   always_ff @(posedge clk) begin
      if (w_pushOk && !rst) r_mem[r_wrPtr] <= {r_ascii, w_data};
   end

   // FIFO pointers, occupancy and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
         if (w_pushOk && !w_pop)      r_count <= r_count + 1'b1;
         else if (w_pop && !w_pushOk) r_count <= r_count - 1'b1;
         if (w_push && !w_pushOk)     r_overflow <= 1'b1;
      end
   end

   assign readyForTransferOut = r_rdy;
   assign localScannerOut     = r_scan;
   assign dataOut             = r_mem[r_rdPtr][WORD_W-1:0];
   assign dataAscii           = r_mem[r_rdPtr][WORD_W];
   assign dataValid           = (r_count != '0);
   assign fifoFull            = w_full;
   assign overflow            = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_transfer_channel_rx.sv
//------------------------------------------------------------------------------
// Module      : tb_transfer_channel_rx
// Description : Randomized bench for transfer_channel_rx with a queue-based
//               reference model of the command/payload protocol.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_transfer_channel_rx;

   localparam int WORD_W      = 8;
   localparam int DEPTH       = 4;
   localparam int PAYLOAD_LEN = 3;
`ifdef TRANSFER_PARITY_EN
   localparam int FRAME = WORD_W + 1;
`else
   localparam int FRAME = WORD_W;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              dataIn = 1'b0;
   logic              bitValid = 1'b0;
   logic              readyForTransferIn = 1'b0;
   logic              readyForTransferOut;
   logic [1:0]        localScannerOut;
   logic [WORD_W-1:0] dataOut;
   logic              dataAscii;
   logic              dataValid;
   logic              dataReady = 1'b0;
   logic              fifoFull;
   logic              overflow;
   logic              parityErr;

   int nTests = 0;
   int nFail  = 0;

   typedef struct {
      logic [WORD_W-1:0] w;
      logic              a;
   } entry_t;

   // Reference model state
   bit        mBits[$];
   entry_t    mQ[$];
   int        mLeft;
   logic      mAscii, mRdy, mOvf, mPerr;
   logic [1:0] mScan;

   transfer_channel_rx #(
      .WORD_W(WORD_W), .DEPTH(DEPTH), .PAYLOAD_LEN(PAYLOAD_LEN)
   ) dut (
      .clk(clk), .rst(rst), .dataIn(dataIn), .bitValid(bitValid),
      .readyForTransferIn(readyForTransferIn),
      .readyForTransferOut(readyForTransferOut),
      .localScannerOut(localScannerOut), .dataOut(dataOut),
      .dataAscii(dataAscii), .dataValid(dataValid), .dataReady(dataReady),
      .fifoFull(fifoFull), .overflow(overflow), .parityErr(parityErr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   task automatic step(input logic rs, input logic bv, input logic din,
                       input logic rin, input logic dr);
      bit popNow, pushNow, parOk, full;
      logic [WORD_W-1:0] w;
      entry_t e;
      rst = rs; bitValid = bv; dataIn = din; readyForTransferIn = rin; dataReady = dr;
      @(posedge clk);
      #1;
      w = '0;
      if (rs) begin
         mBits.delete(); mQ.delete();
         mLeft = 0; mAscii = 0; mRdy = 0; mScan = 0; mOvf = 0; mPerr = 0;
      end else begin
         mScan = 2'b00; mPerr = 1'b0;
         popNow  = (mQ.size() > 0) && dr;
         pushNow = 0;
         if (bv) begin
            mBits.push_back(din);
            if (mBits.size() == FRAME) begin
               for (int i = 0; i < WORD_W; i++) w = {w[WORD_W-2:0], mBits[i]};
               parOk = 1;
`ifdef TRANSFER_PARITY_EN
               parOk = ((^w) == mBits[WORD_W]);
`endif
               mBits.delete();
               if (!parOk) mPerr = 1'b1;
               else if (mLeft > 0) begin
                  pushNow = 1; mRdy = 1'b1; mLeft--;
               end else begin
                  case (w)
                     8'd1: begin mRdy = 1'b0; mScan = 2'b10; end
                     8'd2, 8'd4: mRdy = rin;
                     8'd3: begin mRdy = rin; mScan = 2'b01; end
                     8'd7, 8'd8: begin mRdy = rin; mLeft = PAYLOAD_LEN; mAscii = (w == 8'd8); end
                     default: mRdy = 1'b0;
                  endcase
               end
            end
         end
         full = (mQ.size() == DEPTH);
         if (popNow) void'(mQ.pop_front());
         if (pushNow) begin
            if (full && !popNow) mOvf = 1'b1;
            else begin
               e.w = w; e.a = mAscii;
               mQ.push_back(e);
            end
         end
      end
      check("readyForTransferOut", 32'(readyForTransferOut), 32'(mRdy));
      check("localScannerOut", 32'(localScannerOut), 32'(mScan));
      check("dataValid", 32'(dataValid), 32'(mQ.size() > 0));
      check("fifoFull", 32'(fifoFull), 32'(mQ.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(mOvf));
      check("parityErr", 32'(parityErr), 32'(mPerr));
      if (mQ.size() > 0) begin
         check("dataOut", 32'(dataOut), 32'(mQ[0].w));
         check("dataAscii", 32'(dataAscii), 32'(mQ[0].a));
      end
   endtask

   // drMode: 0 never pop, 1 always pop, 2 random, 3 pop only on the last frame bit
   function automatic logic drv(input int drMode, input bit lastBit);
      case (drMode)
         0: return 1'b0;
         1: return 1'b1;
         3: return lastBit;
         default: return 1'($urandom_range(1));
      endcase
   endfunction

   task automatic sendFrame(input logic [FRAME-1:0] f, input logic rin,
                            input int drMode, input int idlePct);
      for (int i = FRAME - 1; i >= 0; i--) begin
         while (int'($urandom_range(99)) < idlePct)
            step(1'b0, 1'b0, 1'($urandom_range(1)), rin, drv(drMode, 1'b0));
         step(1'b0, 1'b1, f[i], rin, drv(drMode, i == 0));
      end
   endtask

   task automatic sendWord(input logic [WORD_W-1:0] w, input logic rin,
                           input int drMode, input int idlePct);
      logic [FRAME-1:0] f;
`ifdef TRANSFER_PARITY_EN
      f = {w, ^w};
`else
      f = w;
`endif
      sendFrame(f, rin, drMode, idlePct);
   endtask

   initial begin
      logic [WORD_W-1:0] w;
      // Reset state
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Start-scan command with upstream ready
      sendWord(8'h03, 1'b1, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // ASCII payload, then a flush command
      sendWord(8'h08, 1'b1, 0, 0);
      sendWord(8'h41, 1'b0, 0, 0);
      sendWord(8'h42, 1'b0, 0, 10);
      sendWord(8'h43, 1'b0, 0, 10);
      sendWord(8'h01, 1'b1, 0, 0);

      // Reset mid-word discards the partial bits
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      sendWord(8'h01, 1'b0, 0, 0);

      // Fill the FIFO, pop+push on a full FIFO, then overflow
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      sendWord(8'h07, 1'b1, 0, 0);
      for (int i = 0; i < 3; i++) sendWord(8'(8'hA0 + i), 1'b0, 0, 0);
      sendWord(8'h07, 1'b0, 0, 0);
      sendWord(8'hB0, 1'b0, 0, 0);
      sendWord(8'hB1, 1'b0, 3, 0);
      sendWord(8'hB2, 1'b0, 0, 0);
      repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef TRANSFER_PARITY_EN
      // Start-scan word with a wrong parity bit is rejected
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      sendFrame({8'h03, 1'b1}, 1'b1, 0, 0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(49) == 0) begin
            for (int i = 0; i < int'($urandom_range(FRAME - 1)); i++)
               step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
            step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0, 1'($urandom_range(1)));
         end
         if ($urandom_range(9) < 6) w = 8'($urandom_range(1, 9));
         else                       w = 8'($urandom);
`ifdef TRANSFER_PARITY_EN
         if ($urandom_range(9) == 0)
            sendFrame({w, ~(^w)}, 1'($urandom_range(1)), int'($urandom_range(2)), 20);
         else
`endif
         sendWord(w, 1'($urandom_range(1)), int'($urandom_range(2)), 20);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

`default_nettype wire
